stream_fifo: RTL
================

# stream_fifo

Synchronous first-word-fall-through FIFO on one `stream` channel (data plus `_valid`/`_ready`). It sits directly downstream of `io_stream_read_write_array`'s read-data output `sR`. It decouples array read results from a consumer that may stall, without forcing the array reader to drop or repeat accesses. It is also used standalone as a generic elastic buffer between any two stream stages.

## Interface
Parameters:
- `N`, default `` `intN `` (8): data width in bits.
- `DEPTH_LOG2`, default 3: log2 of the storage depth. Depth `D = 2**DEPTH_LOG2` entries (8 by default).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in`  in  N  write data.
- `in_valid`  in  1  producer offers `in`.
- `in_ready`  out  1  FIFO accepts `in` this cycle.
- `out`  out  N  head-of-queue data.
- `out_valid`  out  1  `out` holds a valid entry.
- `out_ready`  in  1  consumer takes `out` this cycle.
- `count`  out  DEPTH_LOG2+1  number of stored entries, range 0..D.

## Operation
- Storage: D×N register array plus `wr_ptr` and `rd_ptr`, each DEPTH_LOG2 bits and wrapping modulo D. `count` is kept as a separate register.
- Push: occurs when `in_valid && in_ready`. It writes `mem[wr_ptr] <= in` and sets `wr_ptr <= wr_ptr+1`.
- Pop: occurs when `out_valid && out_ready`. It sets `rd_ptr <= rd_ptr+1`.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
  - neither: unchanged
- `in_ready = !rst && (count != D)`. This is combinational from registered state only. There is no pass-through path: a full FIFO refuses a push even when a pop happens in the same cycle.
- `out_valid = !rst && (count != 0)`.
- `out = out_valid ? mem[rd_ptr] : 0`. This is an asynchronous read of registered storage, so the head is visible without an extra cycle.
- Full/empty is decided by `count` alone. Pointer equality is never used for this.
- Simultaneous push and pop on an empty FIFO: impossible, because `out_valid=0`. Only the push takes effect.
- Simultaneous push and pop on a full FIFO: impossible, because `in_ready=0`. Only the pop takes effect.
- Simultaneous push and pop at any other count: both take effect and the pointers advance independently.
- Wrap-around: the pointers roll from D−1 to 0 with no gap or bubble.
- `in` and `out_ready` are ignored while their paired handshake signal is low. Data is never altered on a refused push.

## Timing
- Reset, sampled at a rising edge with `rst=1`:
  - `wr_ptr`, `rd_ptr` and `count` are cleared to 0.
  - Storage contents are not cleared.
- While `rst=1`: `in_ready=0`, `out_valid=0`, `out=0`. From the first edge with `rst=1`, `count=0`.
- Reset during operation discards all entries at that edge. Any handshake presented in that cycle is neither accepted nor popped.
- First cycle after reset deasserts: `in_ready=1`, `out_valid=0`, `count=0`.
- Latency: a word accepted at edge k appears on `out` with `out_valid=1` in the cycle after edge k, provided the FIFO was empty.
- Throughput: one push and one pop per cycle sustained at any occupancy from 1 to D−1.
- Ordering: strict FIFO. Output order always equals accepted input order.
- `count` is a registered output and reflects the handshakes of the previous edge.

## Test plan
- Reset and idle:
  - Stimulus: hold `rst=1` for 2 cycles, then release.
  - Required: `in_ready=0`, `out_valid=0`, `out=0` during reset. Then `in_ready=1`, `count=0`, `out_valid=0`.
- Fill and drain:
  - Stimulus: with `out_ready=0`, push `i*7` for i=0..7.
  - Required: `count` rises 1..8, and `in_ready=0` once `count=8`.
  - Stimulus: a 9th push of 99 with `in_valid=1`.
  - Required: the 9th push is not accepted.
  - Stimulus: set `out_ready=1`.
  - Required: `out` reads 0,7,14,…,49 on consecutive cycles, then `out_valid=0`, `count=0`.
- Streaming wrap-around:
  - Stimulus: `in_valid=out_ready=1` continuously for 20 words, values 1..20.
  - Required: each word appears one cycle after its push, `count` stays at 1, and the pointers wrap twice with no loss.
- Full-simultaneous:
  - Stimulus: at `count=8`, assert `in_valid` and `out_ready` together.
  - Required: only the pop occurs, and `count` becomes 7. On the next cycle the push is accepted and `count` returns to 8.
- Random backpressure:
  - Stimulus: drive `in_valid` and `out_ready` from independent random bits for 500 cycles.
  - Required: a scoreboard confirms in-order, lossless, duplicate-free delivery, and `count` always equals pushes minus pops.
- Reset mid-operation:
  - Stimulus: with `count=5`, assert `rst` for one cycle while `in_valid=out_ready=1`.
  - Required: `count=0` and `out_valid=0` immediately after. A subsequent push of 42 emerges as the next `out`.

Source files
------------

// File: rtl/stream_fifo.sv
// stream_fifo
// -----------------------------------------------------------------------------
// First-word-fall-through elastic buffer on a single valid/ready stream. It
// absorbs consumer stalls so an upstream producer (e.g. an array reader) never
// has to drop or repeat a transfer. The head entry is read asynchronously from
// registered storage, so a word pushed into an empty FIFO is visible on `out`
// in the very next cycle.
//
// Parameters
//   N           data width in bits
//   DEPTH_LOG2  log2 of the number of storage entries (D = 2**DEPTH_LOG2)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous, active-high reset (clears pointers and count)
//   in         in   write data
//   in_valid   in   producer offers `in`
//   in_ready   out  FIFO accepts `in` this cycle
//   out        out  head-of-queue data (0 when empty or in reset)
//   out_valid  out  `out` holds a valid entry
//   out_ready  in   consumer takes `out` this cycle
//   count      out  number of stored entries, 0..D
// -----------------------------------------------------------------------------
`ifndef intN
`define intN 8
`endif

module stream_fifo #(
  parameter int N          = `intN,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N-1:0]          out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int D = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(D);

  // Storage is data only: it is never reset, pointers and count define validity.
  logic [N-1:0]          mem_q [D];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q,  count_d;

  logic push;
  logic pop;

  // Full/empty come from the count register alone; pointers are equal both
  // when empty and when full, so they cannot disambiguate. Ready depends only
  // on registered state, so a full FIFO refuses a push even while popping.
  always_comb begin
    in_ready  = !rst && (count_q != FULL_CNT);
    out_valid = !rst && (count_q != '0);
    out       = out_valid ? mem_q[rd_ptr_q] : '0;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are DEPTH_LOG2 bits wide, so the increment wraps D-1 -> 0.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  // push is already gated by !rst through in_ready.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in;
  end

  assign count = count_q;

endmodule
